// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with hardwired-zero x0,
// optional write-to-read bypass, a pending-write scoreboard for RAW hazard
// detection, and a post-reset clear sequencer that zeroes the array one entry
// per cycle instead of resetting it directly.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rv,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     wdata,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                ready
);

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
    logic            ready_nxt;
    logic [NREG-1:0] busy, busy_nxt;
    logic [XLEN-1:0] mem [NREG];

    logic wr_en;
    assign wr_en = we && (rd != '0);

    // Control state: FSM, clear counter, ready flag and scoreboard bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
            busy    <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            ready   <= ready_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state logic: walk the array in CLEAR, track pending writes in RUN.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready_nxt   = ready;
        busy_nxt    = busy;
        case (state)
            CLEAR: begin
                busy_nxt    = '0;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST) begin
                    state_nxt = RUN;
                    ready_nxt = 1'b1;
                end
            end
            RUN: begin
                // Issue is applied after the write-back clear so a new
                // producer of the same register keeps it pending.
                if (wr_en) begin
                    busy_nxt[rd] = 1'b0;
                end
                if (iss_valid && (iss_rd != '0)) begin
                    busy_nxt[iss_rd] = 1'b1;
                end
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
        busy_nxt[0] = 1'b0;
    end

    // Array storage: no reset; zeroed by the clear sequencer after reset.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[rd] <= wdata;
        end
    end

    // Combinational read ports with x0 forced to zero and optional bypass.
    always_comb begin
        rv    = '0;
        rbusy = '0;
        if (state == RUN) begin
            for (int k = 0; k < NRD; k++) begin
                if (rs[k*AW +: AW] != '0) begin
                    if ((BYPASS != 0) && we && (rd == rs[k*AW +: AW])) begin
                        rv[k*XLEN +: XLEN] = wdata;
                    end else begin
                        rv[k*XLEN +: XLEN] = mem[rs[k*AW +: AW]];
                    end
                end
                // Registered state only: a same-cycle write does not hide it.
                rbusy[k] = busy[rs[k*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven, scoreboarded bench for regfile_sb covering the
// clear sequence, x0, bypass on/off, the scoreboard and a 64-bit/16-entry/3-port
// configuration.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, iv;
    logic [4:0]  rd, ird;
    logic [31:0] wdata;
    logic [9:0]  rs;
    logic [63:0] rv_a, rv_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic        ready_a, ready_b;

    logic         we_p, iv_p;
    logic [3:0]   rd_p, ird_p;
    logic [63:0]  wdata_p;
    logic [11:0]  rs_p;
    logic [191:0] rv_p;
    logic [2:0]   rbusy_p;
    logic         ready_p;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst), .rs(rs), .rv(rv_a), .rbusy(rbusy_a),
        .we(we), .rd(rd), .wdata(wdata), .iss_valid(iv), .iss_rd(ird),
        .ready(ready_a)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs(rs), .rv(rv_b), .rbusy(rbusy_b),
        .we(we), .rd(rd), .wdata(wdata), .iss_valid(iv), .iss_rd(ird),
        .ready(ready_b)
    );

    regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) dut_p (
        .clk(clk), .rst(rst), .rs(rs_p), .rv(rv_p), .rbusy(rbusy_p),
        .we(we_p), .rd(rd_p), .wdata(wdata_p), .iss_valid(iv_p), .iss_rd(ird_p),
        .ready(ready_p)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] e_rv0;
        logic [31:0] e_rv1;
        logic [1:0]  e_busy;
        logic [31:0] e_nb0;
    } vec_t;

    vec_t tbl [15];
    vec_t exp_q [$];
    vec_t mon_e;
    int   vidx = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        we    = v.we;
        rd    = v.rd;
        wdata = v.wd;
        iv    = v.iv;
        ird   = v.ird;
        rs    = {v.rs1, v.rs0};
        exp_q.push_back(v);
    endtask

    task automatic idle();
        we = 1'b0; rd = '0; wdata = '0; iv = 1'b0; ird = '0;
    endtask

    // Scoreboard: compare the same-cycle read result of each driven vector.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("v%0d.rv0", vidx), {32'h0, rv_a[31:0]}, {32'h0, mon_e.e_rv0});
            check($sformatf("v%0d.rv1", vidx), {32'h0, rv_a[63:32]}, {32'h0, mon_e.e_rv1});
            check($sformatf("v%0d.rbusy", vidx), {62'h0, rbusy_a}, {62'h0, mon_e.e_busy});
            check($sformatf("v%0d.nb_rv0", vidx), {32'h0, rv_b[31:0]}, {32'h0, mon_e.e_nb0});
            vidx++;
        end
    end

    initial begin
        //              we rd  wdata          iv ird rs0 rs1 rv0            rv1            busy   nb_rv0
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 32'h0};
        tbl[1]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00, 32'h0};
        tbl[3]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 32'hA5A5A5A5};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 32'h0,        32'h0,        2'b00, 32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h0,        32'h0,        2'b01, 32'h0};
        tbl[7]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd9, 5'd9, 32'h99,       32'h99,       2'b11, 32'h0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h99,       32'h99,       2'b00, 32'h99};
        tbl[9]  = '{1'b1, 5'd9, 32'h100,      1'b1, 5'd9, 5'd9, 5'd0, 32'h100,      32'h0,        2'b00, 32'h99};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h100,      32'h100,      2'b11, 32'h100};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'h100,      2'b10, 32'h0};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h100,      2'b10, 32'h0};
        tbl[13] = '{1'b1, 5'd9, 32'h200,      1'b0, 5'd0, 5'd9, 5'd0, 32'h200,      32'h0,        2'b01, 32'h100};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3, 32'h200,      32'h0,        2'b00, 32'h200};

        rst = 1'b1;
        idle();
        rs = '0;
        we_p = 1'b0; rd_p = '0; wdata_p = '0; iv_p = 1'b0; ird_p = '0; rs_p = '0;

        // Reset held for three edges, then released between edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", {63'h0, ready_a}, 64'h0);
        check("rst.rbusy", {62'h0, rbusy_a}, 64'h0);
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("clr.ready@%0d", e), {63'h0, ready_a}, {63'h0, (e == 32)});
            if (e == 15 || e == 16)
                check($sformatf("clr.ready_p@%0d", e), {63'h0, ready_p}, {63'h0, (e >= 16)});
            if (e == 1)
                check("clr.rv", rv_a, 64'h0);
        end
        check("clr.ready_nb", {63'h0, ready_b}, 64'h1);

        // Every register reads zero and not busy after the clear sequence.
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            rs = {5'(i), 5'(i)};
            #1;
            check($sformatf("sweep.rv[%0d]", i), rv_a, 64'h0);
            check($sformatf("sweep.rbusy[%0d]", i), {62'h0, rbusy_a}, 64'h0);
        end

        // Table vectors through the scoreboard.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i]);
        end
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        check("queue.drained", 64'(exp_q.size()), 64'h0);

        // 64-bit, 16-entry, 3-port instance: bypass then stored value on all ports.
        @(posedge clk);
        #1;
        we_p = 1'b1; rd_p = 4'd15; wdata_p = 64'h0123_4567_89AB_CDEF;
        rs_p = {4'd15, 4'd15, 4'd15};
        #2;
        for (int k = 0; k < 3; k++)
            check($sformatf("p.byp.rv%0d", k), rv_p[k*64 +: 64], 64'h0123_4567_89AB_CDEF);
        @(posedge clk);
        #1;
        we_p = 1'b0; wdata_p = '0;
        #2;
        for (int k = 0; k < 3; k++)
            check($sformatf("p.rd.rv%0d", k), rv_p[k*64 +: 64], 64'h0123_4567_89AB_CDEF);

        // Mid-operation asynchronous reset.
        @(posedge clk);
        #1;
        we = 1'b1; rd = 5'd3; wdata = 32'h11;
        @(posedge clk);
        #1;
        rd = 5'd4; wdata = 32'h22; iv = 1'b1; ird = 5'd4;
        @(posedge clk);
        #1;
        idle();
        rs = {5'd4, 5'd3};
        #2;
        check("mid.pre.rv", rv_a, 64'h0000_0022_0000_0011);
        check("mid.pre.rbusy", {62'h0, rbusy_a}, 64'h2);
        #1;
        rst = 1'b1;
        #1;
        check("mid.ready", {63'h0, ready_a}, 64'h0);
        check("mid.rbusy", {62'h0, rbusy_a}, 64'h0);
        check("mid.rv", rv_a, 64'h0);
        check("mid.ready_p", {63'h0, ready_p}, 64'h0);
        #1;
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 31 || e == 32)
                check($sformatf("mid.ready@%0d", e), {63'h0, ready_a}, {63'h0, (e == 32)});
            if (e == 15 || e == 16)
                check($sformatf("mid.ready_p@%0d", e), {63'h0, ready_p}, {63'h0, (e >= 16)});
        end
        check("mid.post.rv", rv_a, 64'h0);
        check("mid.post.rbusy", {62'h0, rbusy_a}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write, two-read RV32I integer register file.
- Multi-read-port register array with hardwired-zero x0 and optional write-to-read bypass.
- Adds a pending-write scoreboard so the issue stage can detect RAW hazards on multicycle results (loads, future mul/div).
- Adds a post-reset clear sequencer so every architectural register reads 0 without a wide async reset on the array.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, >= 2.
- AW, log2(NREG) = 5, register address width; derived, not overridden.
- NRD, 2, number of combinational read ports.
- BYPASS, 1, 1 = write data forwarded to same-cycle reads of the same address; 0 = reads return the stored value.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
- rv  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
- rbusy  out  NRD  1 = register addressed by port k has a pending write.
- we  in  1  write enable.
- rd  in  AW  write address.
- wdata  in  XLEN  write data.
- iss_valid  in  1  marks iss_rd as pending (instruction issued with a destination).
- iss_rd  in  AW  destination being issued.
- ready  out  1  1 = clear sequence complete, block usable.

Behaviour:
- Clock and reset are fixed: one clock (clk); rst is asynchronous and active-high.
- Two-state FSM:
  - CLEAR: entered asynchronously on rst; clr_cnt = 0, scoreboard = all zero, ready = 0.
  - RUN: normal operation.
- While rst is high, state holds CLEAR and clr_cnt holds 0.
- In CLEAR, each rising edge writes 0 to mem[clr_cnt] and increments clr_cnt.
  - The edge that clears entry NREG-1 moves the FSM to RUN and sets ready = 1 (registered).
  - ready therefore rises after exactly NREG edges following rst deassertion (32 by default).
- In CLEAR:
  - rv = 0 and rbusy = 0 on all ports.
  - we and iss_valid are ignored.
- rst asserted mid-CLEAR or mid-RUN: immediately returns to CLEAR, clr_cnt = 0, scoreboard cleared, ready = 0. Array contents are not reset directly; they are re-cleared by the sequence.
- Reads (RUN) are combinational, zero latency:
  - rs = 0 always returns 0, regardless of the array content.
  - BYPASS = 1 and we && rd == rs_k && rd != 0: rv_k = wdata in the same cycle.
  - Otherwise rv_k = mem[rs_k].
- Writes (RUN):
  - On the edge with we = 1 and rd != 0, mem[rd] <= wdata.
  - Writes to rd = 0 are discarded; x0 is never written.
- Scoreboard (RUN):
  - NREG busy bits, bit 0 hardwired 0.
  - On each edge: if we and rd != 0, clear busy[rd]; then if iss_valid and iss_rd != 0, set busy[iss_rd]. Set wins when iss_rd == rd in the same cycle (new producer pending).
  - rbusy_k = busy[rs_k], registered state only; a same-cycle write does not clear it combinationally.
  - Writes to a non-busy register are legal and leave busy at 0.
- Multiple read ports may use the same address; all return identical data.

Test Plan:
- Reset sequencing: rst high 3 cycles, release -> ready = 0 for 31 edges, 1 after the 32nd. Every rs 0..31 then reads 0x00000000 with rbusy = 0.
- Write/read and x0: we = 1, rd = 5, wdata = 0xDEADBEEF -> next cycle rs0 = 5 reads 0xDEADBEEF. we = 1, rd = 0, wdata = 0x12345678 -> rs1 = 0 still reads 0.
- Bypass: BYPASS = 1, we = 1, rd = 7, wdata = 0xA5A5A5A5 with rs0 = 7 in the same cycle -> rv0 = 0xA5A5A5A5 that cycle. With BYPASS = 0, rv0 shows the old value (0) that cycle and 0xA5A5A5A5 the next.
- Scoreboard:
  - iss_valid, iss_rd = 9 -> next cycle rbusy0 = 1 for rs0 = 9.
  - Write rd = 9 -> rbusy0 = 0 the following cycle.
  - Same-cycle write rd = 9 and issue iss_rd = 9 -> busy stays 1.
  - iss_rd = 0 -> never busy.
- Reset mid-operation: registers 3/4 written with 0x11/0x22, busy[4] set, rst pulsed asynchronously between edges -> ready drops immediately and rbusy = 0. After 32 edges, registers 3 and 4 read 0.
- Parametrisation: XLEN = 64, NREG = 16, NRD = 3 -> ready after 16 edges. A 64-bit write to rd = 15 is read back on all three ports simultaneously.
